// File: rtl/lbmem_ctrl.sv
// Line-buffer sequencer: purge after reset, stream one frame in, pad-flush the tail.
// Optional LBMEM_CTRL_MARKERS_EN adds out_eol/out_eof framing markers.
`timescale 1ns/1ps
module lbmem_ctrl #(
  parameter int unsigned       WIDTH = 16,
  parameter int unsigned       IMG_W = 64,
  parameter int unsigned       IMG_H = 64,
  parameter int unsigned       FILL  = 8,
  parameter logic [WIDTH-1:0]  PAD   = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef LBMEM_CTRL_MARKERS_EN
  output logic             out_eol,
  output logic             out_eof,
`endif
  output logic [WIDTH-1:0] lb_wdata,
  output logic             lb_wen,
  input  logic [WIDTH-1:0] lb_rdata,
  input  logic             lb_valid
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = $clog2(NPIX + 1);
  localparam int unsigned PCW  = $clog2(FILL + 1);

  typedef enum logic [2:0] {StPurge, StIdle, StRun, StFlush, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_in_cnt, r_out_cnt, w_out_next;
  logic [PCW-1:0]  r_pcnt;
  logic            r_seen, r_done, w_done_d;
  logic            w_wen;
  logic [WIDTH-1:0] w_wdata;

  assign in_ready   = (r_state == StRun) && (r_in_cnt < CW'(NPIX)) && !RESET;
  assign out_valid  = lb_valid && (r_out_cnt != r_in_cnt) && (r_state != StPurge) && !RESET;
  assign out_data   = lb_rdata;
  assign w_out_next = r_out_cnt + CW'(out_valid);
  assign busy       = (r_state != StIdle);
  assign done       = r_done;
  assign lb_wen     = w_wen && !RESET;
  assign lb_wdata   = w_wdata;

  always_comb begin
    w_state_d = r_state;
    w_wen     = 1'b0;
    w_wdata   = PAD;
    w_done_d  = 1'b0;
    unique case (r_state)
      StPurge: begin
        // Pad until the buffer starts streaming, then wait for it to empty.
        if (!r_seen && !lb_valid && (r_pcnt < PCW'(FILL))) w_wen = 1'b1;
        if (r_seen && !lb_valid) w_state_d = StIdle;
      end
      StIdle: begin
        if (start) w_state_d = StRun;
      end
      StRun: begin
        w_wdata = in_data;
        w_wen   = in_valid && in_ready;
        if (w_wen && (r_in_cnt == CW'(NPIX - 1))) w_state_d = StFlush;
      end
      StFlush: begin
        if (w_out_next < r_in_cnt) w_wen = 1'b1;
        else                       w_state_d = StDrain;
      end
      StDrain: begin
        if (!lb_valid) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StPurge;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= StPurge;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_pcnt    <= '0;
      r_seen    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_done_d;
      if (r_state == StPurge) begin
        if (lb_valid) r_seen <= 1'b1;
        if (lb_wen)   r_pcnt <= r_pcnt + 1'b1;
      end
      if ((r_state == StIdle) && start) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (lb_wen && (r_state == StRun)) r_in_cnt <= r_in_cnt + 1'b1;
        if (out_valid) r_out_cnt <= w_out_next;
      end
    end
  end

`ifdef LBMEM_CTRL_MARKERS_EN
  localparam int unsigned XW = $clog2(IMG_W + 1);
  localparam int unsigned YW = $clog2(IMG_H + 1);

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          w_last_col;

  assign w_last_col = (r_col == XW'(IMG_W - 1));
  assign out_eol    = out_valid && w_last_col;
  assign out_eof    = out_eol && (r_row == YW'(IMG_H - 1));

  always_ff @(posedge CLK) begin
    if (RESET || ((r_state == StIdle) && start)) begin
      r_col <= '0;
      r_row <= '0;
    end else if (out_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lbmem_ctrl.sv
// Bench for lbmem_ctrl: two instances (4x4 and 2x2) each on a behavioural line-buffer model,
// with a pixel-order scoreboard. Honours LBMEM_CTRL_MARKERS_EN when defined.
`timescale 1ns/1ps
module tb_lbmem_ctrl;

  logic        clk = 1'b0;
  logic        RESET [2];
  logic        start [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] in_data [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] out_data [2];
  logic        out_valid [2];
  logic        out_eol [2];
  logic        out_eof [2];
  logic [15:0] lb_wdata [2];
  logic        lb_wen [2];
  logic [15:0] lb_rdata [2];
  logic        lb_valid [2];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  lbmem_ctrl #(.WIDTH(16), .IMG_W(4), .IMG_H(4), .FILL(8), .PAD(16'h0000)) u_dut0 (
    .CLK(clk), .RESET(RESET[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]),
`ifdef LBMEM_CTRL_MARKERS_EN
    .out_eol(out_eol[0]), .out_eof(out_eof[0]),
`endif
    .lb_wdata(lb_wdata[0]), .lb_wen(lb_wen[0]), .lb_rdata(lb_rdata[0]), .lb_valid(lb_valid[0])
  );

  lbmem_ctrl #(.WIDTH(16), .IMG_W(2), .IMG_H(2), .FILL(8), .PAD(16'h0000)) u_dut1 (
    .CLK(clk), .RESET(RESET[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]),
`ifdef LBMEM_CTRL_MARKERS_EN
    .out_eol(out_eol[1]), .out_eof(out_eof[1]),
`endif
    .lb_wdata(lb_wdata[1]), .lb_wen(lb_wen[1]), .lb_rdata(lb_rdata[1]), .lb_valid(lb_valid[1])
  );

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int GW = (g == 0) ? 4 : 2;
    localparam int GN = GW * GW;

    // Line buffer: FIFO that starts emitting once 8 words are held and then emits every
    // cycle until empty. Starts pre-loaded with 5 stale words.
    logic [15:0] mem [64];
    logic [5:0]  rp = 6'd0;
    logic [5:0]  wp = 6'd5;
    int          cnt = 5;
    logic        v_q = 1'b0;
    logic [15:0] d_q = 16'h0;
    int          cnt_w;
    logic        pop;

    always_comb begin
      cnt_w = cnt + (lb_wen[g] ? 1 : 0);
      pop   = (v_q && cnt_w != 0) || (cnt_w >= 8);
    end

    always @(posedge clk) begin
      if (lb_wen[g]) begin
        mem[wp] <= lb_wdata[g];
        wp      <= wp + 6'd1;
      end
      if (pop) begin
        d_q <= (cnt == 0) ? lb_wdata[g] : mem[rp];
        rp  <= rp + 6'd1;
      end
      cnt <= cnt_w - (pop ? 1 : 0);
      v_q <= pop;
    end

    assign lb_valid[g] = v_q;
    assign lb_rdata[g] = d_q;

    // Scoreboard: accepted pixels must come out once each, in order, only inside a frame.
    logic [15:0] q[$];
    int out_n = 0, done_n = 0, wen_n = 0, idx = 0, lat = -1, first_wr = -1;
    bit armed = 0, pend = 0;

    always @(negedge clk) begin
      if (RESET[g]) begin
        q.delete();
        armed = 0;
        check($sformatf("rst_out_valid%0d", g), out_valid[g], 0);
        check($sformatf("rst_in_ready%0d", g), in_ready[g], 0);
      end else begin
        if (start[g] && busy[g] === 1'b0) begin
          armed = 1; pend = 1; idx = 0; first_wr = -1;
        end
        if (lb_wen[g]) wen_n++;
        if (in_valid[g] && in_ready[g]) begin
          q.push_back(in_data[g]);
          if (first_wr < 0) first_wr = cyc;
        end
        if (out_valid[g] === 1'b1) begin
          check($sformatf("out_in_frame%0d", g), armed, 1);
          if (q.size() == 0) check($sformatf("out_extra%0d", g), 0, 1);
          else check($sformatf("out_data%0d_%0d", g, idx), out_data[g], q.pop_front());
`ifdef LBMEM_CTRL_MARKERS_EN
          check($sformatf("eol%0d_%0d", g, idx), out_eol[g], (idx % GW) == GW - 1);
          check($sformatf("eof%0d_%0d", g, idx), out_eof[g], idx == GN - 1);
`endif
          if (pend) begin lat = cyc - first_wr; pend = 0; end
          idx++;
          out_n++;
        end
        if (done[g]) done_n++;
      end
    end
  end

  function automatic int get_out(input int k);
    return (k == 0) ? gm[0].out_n : gm[1].out_n;
  endfunction
  function automatic int get_done(input int k);
    return (k == 0) ? gm[0].done_n : gm[1].done_n;
  endfunction
  function automatic int get_wen(input int k);
    return (k == 0) ? gm[0].wen_n : gm[1].wen_n;
  endfunction
  function automatic int get_qsz(input int k);
    return (k == 0) ? gm[0].q.size() : gm[1].q.size();
  endfunction

  task automatic wait_idle(input int k, input int lim, input string tag);
    int i = 0;
    while (busy[k] !== 1'b0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_idle_timeout"}, i < lim, 1);
    @(posedge clk); #1;
  endtask

  // Feeds up to maxpx pixels; a stray start pulse rides along on pixel 5.
  task automatic drive_frame(input int k, input int maxpx, input int gap_at, input int gap_len,
                             input bit rnd, input string tag);
    int idx = 0, gc = 0, guard = 0;
    bit have = 0, acc, v;
    logic [15:0] cur = 16'h0;
    while (idx < maxpx && guard < 2000) begin
      if (!have) begin
        cur  = rnd ? 16'($urandom_range(1, 65535)) : 16'(idx + 1);
        have = 1;
      end
      v = 1;
      if (idx == gap_at && gc < gap_len) begin v = 0; gc++; end
      if (rnd && $urandom_range(0, 3) == 0) v = 0;
      in_valid[k] = v;
      in_data[k]  = cur;
      start[k]    = (idx == 5);
      @(negedge clk);
      acc = in_valid[k] && in_ready[k];
      @(posedge clk); #1;
      if (acc) begin idx++; have = 0; end
      guard++;
    end
    in_valid[k] = 0;
    start[k]    = 0;
    check({tag, "_accepted"}, idx, maxpx);
  endtask

  task automatic start_frame(input int k);
    start[k] = 1;
    @(posedge clk); #1;
    start[k] = 0;
  endtask

  task automatic run_frame(input int k, input int n, input int gap_at, input int gap_len,
                           input bit rnd, input int exp_wen, input string tag);
    int o0 = get_out(k), d0 = get_done(k), w0 = get_wen(k);
    start_frame(k);
    check({tag, "_busy"}, busy[k], 1);
    drive_frame(k, n, gap_at, gap_len, rnd, tag);
    wait_idle(k, 400, tag);
    repeat (3) @(posedge clk); #1;
    check({tag, "_outputs"}, get_out(k) - o0, n);
    check({tag, "_done_pulses"}, get_done(k) - d0, 1);
    check({tag, "_leftover"}, get_qsz(k), 0);
    if (exp_wen >= 0) check({tag, "_writes"}, get_wen(k) - w0, exp_wen);
  endtask

  initial begin
    int o0, d0, w0;
    for (int k = 0; k < 2; k++) begin
      RESET[k] = 1; start[k] = 0; in_valid[k] = 0; in_data[k] = 16'h0;
    end
    repeat (3) @(posedge clk); #1;
    RESET[0] = 0; RESET[1] = 0;
    wait_idle(0, 100, "purge0");
    wait_idle(1, 100, "purge1");
    check("purge_pads0", get_wen(0), 3);
    check("purge_pads1", get_wen(1), 3);
    check("purge_out0", get_out(0), 0);
    check("purge_done0", get_done(0), 0);
    check("idle_ready0", in_ready[0], 0);

    // 16 back-to-back pixels: 16 real + 7 pad writes, first output 8 cycles in.
    run_frame(0, 16, -1, 0, 0, 23, "frameA");
    check("frameA_latency", gm[0].lat, 8);

    run_frame(0, 16, 12, 10, 0, 23, "frameB");

    // 4-pixel frame: everything leaves during the pad flush.
    run_frame(1, 4, -1, 0, 0, 11, "frameC");

    // Mid-frame reset after 6 pixels: 2 pads to get streaming, no output.
    o0 = get_out(0); d0 = get_done(0);
    start_frame(0);
    drive_frame(0, 6, -1, 0, 0, "frameD");
    RESET[0] = 1;
    @(posedge clk); #1;
    RESET[0] = 0;
    w0 = get_wen(0);
    wait_idle(0, 100, "repurge");
    check("repurge_pads", get_wen(0) - w0, 2);
    check("repurge_out", get_out(0) - o0, 0);
    check("repurge_done", get_done(0) - d0, 0);
    run_frame(0, 16, -1, 0, 0, 23, "frameE");

    for (int r = 0; r < 3; r++) run_frame(0, 16, -1, 0, 1, -1, $sformatf("rand0_%0d", r));
    for (int r = 0; r < 2; r++) run_frame(1, 4, -1, 0, 1, -1, $sformatf("rand1_%0d", r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lbmem_ctrl.md
Name: lbmem_ctrl

Overview:
Sequencer for the 64-entry, 16-bit line-buffer memory, which has a fill depth of 8, no reset and no read enable. Accepts one frame of pixels from an upstream valid/ready stream and drives the buffer's write port. Filters the buffer output so only real frame pixels reach downstream. At end of frame it injects pad writes to push out the tail, and after reset it purges any stale buffer contents.

Parameters:
WIDTH, 16, pixel width; must match the line-buffer data width
IMG_W, 64, pixels per line
IMG_H, 64, lines per frame
FILL, 8, line-buffer fill depth (number of writes before lb_valid rises)
PAD, 16'h0000, data value written during purge and flush

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  pulse; begins a frame when in IDLE, ignored otherwise
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a frame has fully left the buffer
in_data  in  WIDTH  upstream pixel
in_valid  in  1  upstream valid
in_ready  out  1  high in RUN while in_cnt < IMG_W*IMG_H
out_data  out  WIDTH  equals lb_rdata (combinational)
out_valid  out  1  lb_valid & (out_cnt != in_cnt) & state != PURGE; no backpressure
lb_wdata  out  WIDTH  to line buffer wdata
lb_wen  out  1  to line buffer wen
lb_rdata  in  WIDTH  from line buffer rdata
lb_valid  in  1  from line buffer valid

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. RESET forces state=PURGE, in_cnt=out_cnt=0, done=0, in_ready=0, and out_valid=0 for the reset cycle.
- Counters: in_cnt and out_cnt are $clog2(IMG_W*IMG_H+1) bits wide; 13 bits at the defaults.
  - in_cnt increments on each real write.
  - out_cnt increments on each out_valid cycle.
- Line-buffer behaviour the controller relies on:
  - Once lb_valid=1, the buffer emits one word every cycle, with or without writes.
  - With no writes it drains to empty and lb_valid falls.
  - A partially filled buffer (fewer than FILL words, lb_valid=0) holds its data indefinitely.
- Real words leave the buffer in write order, and all pads are written after the last real word. Therefore out_cnt != in_cnt correctly marks a real output.
- States:
  - PURGE: lb_wen=1, lb_wdata=PAD every cycle until lb_valid=1 is seen; at most FILL cycles. Then lb_wen=0 until lb_valid=0, then go to IDLE. Outputs are suppressed throughout.
  - IDLE: lb_wen=0. On start, clear in_cnt and out_cnt and go to RUN.
  - RUN: lb_wen = in_valid & in_ready and lb_wdata = in_data. Input gaps are allowed; a gap may drain the buffer early, which is legal. When in_cnt reaches IMG_W*IMG_H, go to FLUSH.
  - FLUSH: lb_wen=1 with PAD while out_cnt (including this cycle's output) < in_cnt. Then go to DRAIN.
  - DRAIN: lb_wen=0. When lb_valid=0, pulse done and go to IDLE.
- Latency: in RUN with no gaps, the first out_valid occurs FILL cycles after the first accepted write. After the last real write, at most FILL pad cycles are needed.
- Boundary conditions:
  - A start pulse outside IDLE is ignored.
  - When IMG_W*IMG_H < FILL, all output comes out during FLUSH.
  - A RESET mid-frame discards the frame with no out_valid and re-purges.
  - A frame never writes more than IMG_W*IMG_H real words; in_ready drops in the same cycle the count reaches the limit.

Optional Feature:
LBMEM_CTRL_MARKERS_EN:
- Defined: adds out_eol and out_eof outputs (1 bit each), qualified by out_valid. The controller keeps output column and row counters: out_eol=1 on column IMG_W-1, and out_eof=1 on the final pixel (out_cnt = IMG_W*IMG_H-1). Both counters clear on start and RESET.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset with the buffer pre-loaded to 5 words (lb_valid=0) -> exactly 3 PAD writes, lb_valid rises, drains, state reaches IDLE; out_valid never asserted; busy falls.
- IMG_W=4, IMG_H=4, start, then 16 back-to-back pixels 1..16 -> out_valid sequence 1..16 in order; first output 8 cycles after first write; exactly 16 out_valid cycles; one done pulse.
- Same frame with in_valid low for 10 cycles after pixel 12 -> buffer drains pixels early; all 16 pixels still emitted exactly once in order; done asserted.
- IMG_W=2, IMG_H=2 (4 < FILL) -> 4 pixels accepted, FLUSH issues PAD writes, outputs 1..4 only, no PAD ever visible on out_valid.
- RESET asserted after 6 pixels of a 16-pixel frame -> no out_valid; PURGE completes; a new start runs a clean frame 1..16.
- With LBMEM_CTRL_MARKERS_EN and IMG_W=4 -> out_eol on outputs 4, 8, 12, 16; out_eof on output 16 only.
